// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared forwarding-source codes and interrupt FSM encoding
package pipeline_pkg;
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_EX  = 2'b10,
      FWD_WB  = 2'b11
   } fwd_e;
   typedef enum logic [1:0] {
      IRQ_RUN   = 2'b00,
      IRQ_DRAIN = 2'b01,
      IRQ_ACK   = 2'b10
   } irq_state_e;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register busy bits for the in-flight multi-cycle op
module hazard_scoreboard #(
   parameter int RA_W  = 5,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set_en,
   input  logic [RA_W-1:0] set_no,
   input  logic            clr_en,
   input  logic [RA_W-1:0] clr_no,
   input  logic [RA_W-1:0] rd1_no,
   input  logic [RA_W-1:0] rd2_no,
   input  logic [RA_W-1:0] rdw_no,
   output logic            rd1_busy,
   output logic            rd2_busy,
   output logic            rdw_busy
);
   logic [NREGS-1:0] busy;
   // r0 is never marked, so its busy bit stays 0; a same-cycle set wins over a clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else begin
         if (clr_en) busy[clr_no] <= 1'b0;
         if (set_en && set_no != '0) busy[set_no] <= 1'b1;
      end
   end
   assign rd1_busy = busy[rd1_no];
   assign rd2_busy = busy[rd2_no];
   assign rdw_busy = busy[rdw_no];
endmodule

// File: rtl/hazard_unit_sb.sv
// hazard_unit_sb: ID-stage forwarding, load-use/scoreboard stalls and interrupt entry sequencing
module hazard_unit_sb
   import pipeline_pkg::*;
#(
   parameter int RA_W     = 5,
   parameter int NREGS    = 32,
   parameter int LOAD_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic            id_r1_used,
   input  logic [RA_W-1:0] id_r1no,
   input  logic            id_r2_used,
   input  logic [RA_W-1:0] id_r2no,
   input  logic            id_wr_en,
   input  logic [RA_W-1:0] id_wr_no,
   input  logic            id_is_mc,
   input  logic            ex_regwrite,
   input  logic [RA_W-1:0] ex_wr_no,
   input  logic            ex_memread,
   input  logic            mem_regwrite,
   input  logic [RA_W-1:0] mem_wr_no,
   input  logic            wb_regwrite,
   input  logic [RA_W-1:0] wb_wr_no,
   input  logic            mc_done,
   input  logic [RA_W-1:0] mc_wr_no,
   input  logic            branch_taken,
   input  logic            irq_req,
   output logic [1:0]      r1_fwd,
   output logic [1:0]      r2_fwd,
   output logic            stall,
   output logic            flush,
   output logic            irq_ack
);
   irq_state_e state, state_nxt;
   logic [2:0] ld_cnt;
   logic       mc_busy;
   logic       r1_live, r2_live, ld_hit, sb_hazard, flush_in, issue, mc_issue;
   logic       b1, b2, bw;
   assign r1_live = id_r1_used && id_r1no != '0;
   assign r2_live = id_r2_used && id_r2no != '0;
   // forwarding source selection, youngest producer first
   always_comb begin
      r1_fwd = !r1_live ? FWD_RF :
               (ex_regwrite  && ex_wr_no  == id_r1no) ? FWD_EX  :
               (mem_regwrite && mem_wr_no == id_r1no) ? FWD_MEM :
               (wb_regwrite  && wb_wr_no  == id_r1no) ? FWD_WB  : FWD_RF;
      r2_fwd = !r2_live ? FWD_RF :
               (ex_regwrite  && ex_wr_no  == id_r2no) ? FWD_EX  :
               (mem_regwrite && mem_wr_no == id_r2no) ? FWD_MEM :
               (wb_regwrite  && wb_wr_no  == id_r2no) ? FWD_WB  : FWD_RF;
   end
   hazard_scoreboard #(.RA_W(RA_W), .NREGS(NREGS)) u_sb (
      .clk(clk), .rst(rst),
      .set_en(mc_issue), .set_no(id_wr_no),
      .clr_en(mc_done), .clr_no(mc_wr_no),
      .rd1_no(id_r1no), .rd2_no(id_r2no), .rdw_no(id_wr_no),
      .rd1_busy(b1), .rd2_busy(b2), .rdw_busy(bw)
   );
   // hazard detection and the OR of all stall/flush sources
   always_comb begin
      ld_hit    = ex_memread && ((r1_live && ex_wr_no == id_r1no) || (r2_live && ex_wr_no == id_r2no));
      sb_hazard = (id_r1_used && b1) || (id_r2_used && b2) || (id_wr_en && bw) || (id_is_mc && mc_busy);
      stall     = ld_hit || ld_cnt != 3'd0 || sb_hazard || state == IRQ_DRAIN;
      flush_in  = branch_taken || state == IRQ_ACK;
      flush     = stall || flush_in;
      irq_ack   = state == IRQ_ACK;
      issue     = id_valid && !stall && !flush_in;
      mc_issue  = issue && id_is_mc;
   end
   // interrupt entry: wait out load stalls, drain the MC op, then a single ack cycle
   always_comb begin
      state_nxt = state;
      state_nxt = state == IRQ_RUN   ? ((irq_req && ld_cnt == 3'd0) ? (mc_busy ? IRQ_DRAIN : IRQ_ACK) : IRQ_RUN) :
                  state == IRQ_DRAIN ? ((mc_done || !mc_busy) ? IRQ_ACK : IRQ_DRAIN) : IRQ_RUN;
   end
   // state, load-use countdown and MC-in-flight flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IRQ_RUN;
         ld_cnt  <= 3'd0;
         mc_busy <= 1'b0;
      end else begin
         state   <= state_nxt;
         ld_cnt  <= state == IRQ_ACK ? 3'd0 : ld_hit ? 3'(LOAD_LAT - 1) : ld_cnt != 3'd0 ? ld_cnt - 3'd1 : ld_cnt;
         mc_busy <= mc_issue ? 1'b1 : mc_done ? 1'b0 : mc_busy;
      end
   end
endmodule

// File: tb/tb_hazard_unit_sb.sv
// tb_hazard_unit_sb: directed scenario checks for hazard_unit_sb with LOAD_LAT=2
module tb_hazard_unit_sb;
   logic clk = 1'b0, rst;
   logic id_valid, id_r1_used, id_r2_used, id_wr_en, id_is_mc;
   logic [4:0] id_r1no, id_r2no, id_wr_no, ex_wr_no, mem_wr_no, wb_wr_no, mc_wr_no;
   logic ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, mc_done, branch_taken, irq_req;
   logic [1:0] r1_fwd, r2_fwd;
   logic stall, flush, irq_ack;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   hazard_unit_sb #(.RA_W(5), .NREGS(32), .LOAD_LAT(2)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_r1_used(id_r1_used), .id_r1no(id_r1no), .id_r2_used(id_r2_used), .id_r2no(id_r2no),
      .id_wr_en(id_wr_en), .id_wr_no(id_wr_no), .id_is_mc(id_is_mc),
      .ex_regwrite(ex_regwrite), .ex_wr_no(ex_wr_no), .ex_memread(ex_memread),
      .mem_regwrite(mem_regwrite), .mem_wr_no(mem_wr_no),
      .wb_regwrite(wb_regwrite), .wb_wr_no(wb_wr_no),
      .mc_done(mc_done), .mc_wr_no(mc_wr_no), .branch_taken(branch_taken), .irq_req(irq_req),
      .r1_fwd(r1_fwd), .r2_fwd(r2_fwd), .stall(stall), .flush(flush), .irq_ack(irq_ack)
   );

   task automatic idle();
      id_valid = 0; id_r1_used = 0; id_r1no = 0; id_r2_used = 0; id_r2no = 0;
      id_wr_en = 0; id_wr_no = 0; id_is_mc = 0;
      ex_regwrite = 0; ex_wr_no = 0; ex_memread = 0;
      mem_regwrite = 0; mem_wr_no = 0; wb_regwrite = 0; wb_wr_no = 0;
      mc_done = 0; mc_wr_no = 0; branch_taken = 0; irq_req = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if ({r1_fwd, r2_fwd, stall, flush, irq_ack} !== 7'b0) begin errors++; $display("FAIL rst_held got %b exp 0000000", {r1_fwd, r2_fwd, stall, flush, irq_ack}); end
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      checks++; if ({r1_fwd, r2_fwd, stall, flush, irq_ack} !== 7'b0) begin errors++; $display("FAIL rst_released got %b exp 0000000", {r1_fwd, r2_fwd, stall, flush, irq_ack}); end
   endtask

   task automatic test_forwarding();
      step(); idle(); id_valid = 1; id_r1_used = 1; id_r1no = 5;
      ex_regwrite = 1; ex_wr_no = 5; mem_regwrite = 1; mem_wr_no = 5;
      @(negedge clk);
      checks++; if (r1_fwd !== 2'b10) begin errors++; $display("FAIL fwd_ex_over_mem got %b exp 10", r1_fwd); end
      checks++; if ({r2_fwd, stall} !== 3'b000) begin errors++; $display("FAIL fwd_r2_unused got %b exp 000", {r2_fwd, stall}); end
      step(); ex_regwrite = 0;
      @(negedge clk);
      checks++; if (r1_fwd !== 2'b01) begin errors++; $display("FAIL fwd_mem got %b exp 01", r1_fwd); end
      step(); mem_regwrite = 0; wb_regwrite = 1; wb_wr_no = 5; id_r2_used = 1; id_r2no = 5; ex_regwrite = 1; ex_wr_no = 6;
      @(negedge clk);
      checks++; if ({r1_fwd, r2_fwd} !== 4'b1111) begin errors++; $display("FAIL fwd_wb got %b exp 1111", {r1_fwd, r2_fwd}); end
      step(); id_r1_used = 0;
      @(negedge clk);
      checks++; if ({r1_fwd, r2_fwd} !== 4'b0011) begin errors++; $display("FAIL fwd_unused_rf got %b exp 0011", {r1_fwd, r2_fwd}); end
   endtask

   task automatic test_x0();
      step(); idle(); id_valid = 1; id_r2_used = 1; id_r2no = 0;
      ex_regwrite = 1; mem_regwrite = 1; wb_regwrite = 1; ex_memread = 1;
      @(negedge clk);
      checks++; if ({r2_fwd, stall, flush} !== 4'b0000) begin errors++; $display("FAIL x0_no_fwd got %b exp 0000", {r2_fwd, stall, flush}); end
   endtask

   task automatic test_load_use();
      step(); idle(); id_valid = 1; id_r1_used = 1; id_r1no = 7; ex_memread = 1; ex_regwrite = 1; ex_wr_no = 7;
      @(negedge clk);
      checks++; if ({stall, flush, r1_fwd} !== 4'b1110) begin errors++; $display("FAIL ld_c0 got %b exp 1110", {stall, flush, r1_fwd}); end
      step(); ex_memread = 0; ex_regwrite = 0; irq_req = 1;
      @(negedge clk);
      checks++; if ({stall, flush, irq_ack} !== 3'b110) begin errors++; $display("FAIL ld_c1 got %b exp 110", {stall, flush, irq_ack}); end
      step();
      @(negedge clk);
      checks++; if ({stall, flush, irq_ack} !== 3'b000) begin errors++; $display("FAIL ld_c2_irq_waits got %b exp 000", {stall, flush, irq_ack}); end
      step(); irq_req = 0;
      @(negedge clk);
      checks++; if ({stall, flush, irq_ack} !== 3'b011) begin errors++; $display("FAIL ld_irq_ack got %b exp 011", {stall, flush, irq_ack}); end
      step();
      @(negedge clk);
      checks++; if ({stall, flush, irq_ack} !== 3'b000) begin errors++; $display("FAIL ld_irq_done got %b exp 000", {stall, flush, irq_ack}); end
   endtask

   task automatic test_mc();
      step(); idle(); id_valid = 1; id_is_mc = 1; id_wr_en = 1; id_wr_no = 9;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mc_issue got %b exp 0", stall); end
      step(); id_is_mc = 0; id_wr_no = 10; id_r1_used = 1; id_r1no = 9;
      @(negedge clk);
      checks++; if ({stall, flush} !== 2'b11) begin errors++; $display("FAIL mc_raw got %b exp 11", {stall, flush}); end
      step(); id_r1_used = 0; id_wr_no = 9;
      @(negedge clk);
      checks++; if ({stall, flush} !== 2'b11) begin errors++; $display("FAIL mc_waw got %b exp 11", {stall, flush}); end
      step(); mc_done = 1; mc_wr_no = 9;
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mc_done_extra got %b exp 1", stall); end
      step(); mc_done = 0;
      @(negedge clk);
      checks++; if ({stall, flush} !== 2'b00) begin errors++; $display("FAIL mc_released got %b exp 00", {stall, flush}); end
      step(); id_is_mc = 1; id_wr_no = 9;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mc2_issue got %b exp 0", stall); end
      step(); id_wr_no = 12;
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mc_busy_stall got %b exp 1", stall); end
      step(); mc_done = 1; mc_wr_no = 9;
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mc_busy_done_extra got %b exp 1", stall); end
      step(); mc_done = 0;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mc3_issue got %b exp 0", stall); end
   endtask

   task automatic test_irq_drain();
      step(); idle(); irq_req = 1;
      @(negedge clk);
      checks++; if ({stall, irq_ack} !== 2'b00) begin errors++; $display("FAIL irq_run got %b exp 00", {stall, irq_ack}); end
      step();
      @(negedge clk);
      checks++; if ({stall, flush, irq_ack} !== 3'b110) begin errors++; $display("FAIL irq_drain got %b exp 110", {stall, flush, irq_ack}); end
      step(); mc_done = 1; mc_wr_no = 12;
      @(negedge clk);
      checks++; if ({stall, flush, irq_ack} !== 3'b110) begin errors++; $display("FAIL irq_drain_done got %b exp 110", {stall, flush, irq_ack}); end
      step(); mc_done = 0; irq_req = 0;
      @(negedge clk);
      checks++; if ({stall, flush, irq_ack} !== 3'b011) begin errors++; $display("FAIL irq_ack got %b exp 011", {stall, flush, irq_ack}); end
      step(); id_valid = 1; id_r1_used = 1; id_r1no = 12;
      @(negedge clk);
      checks++; if ({stall, flush, irq_ack} !== 3'b000) begin errors++; $display("FAIL irq_back_run got %b exp 000", {stall, flush, irq_ack}); end
   endtask

   task automatic test_rst_drain();
      step(); idle(); id_valid = 1; id_is_mc = 1; id_wr_en = 1; id_wr_no = 9;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rd_issue got %b exp 0", stall); end
      step(); idle(); irq_req = 1;
      @(negedge clk);
      checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL rd_to_drain got %b exp 0", irq_ack); end
      step(); irq_req = 0;
      @(negedge clk);
      checks++; if ({stall, flush, irq_ack} !== 3'b110) begin errors++; $display("FAIL rd_in_drain got %b exp 110", {stall, flush, irq_ack}); end
      #2 rst = 1;
      #1;
      checks++; if ({stall, flush, irq_ack} !== 3'b000) begin errors++; $display("FAIL rd_async_clear got %b exp 000", {stall, flush, irq_ack}); end
      step(); rst = 0; id_valid = 1; id_r1_used = 1; id_r1no = 9; id_is_mc = 1; id_wr_en = 1; id_wr_no = 9;
      @(negedge clk);
      checks++; if ({stall, flush, irq_ack} !== 3'b000) begin errors++; $display("FAIL rd_sb_cleared got %b exp 000", {stall, flush, irq_ack}); end
      step(); idle(); mc_done = 1; mc_wr_no = 9;
      @(negedge clk);
      checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL rd_no_ack got %b exp 0", irq_ack); end
   endtask

   task automatic test_branch();
      step(); idle(); branch_taken = 1;
      @(negedge clk);
      checks++; if ({stall, flush, irq_ack} !== 3'b010) begin errors++; $display("FAIL br_alone got %b exp 010", {stall, flush, irq_ack}); end
      step(); idle(); branch_taken = 1; id_valid = 1; id_is_mc = 1; id_wr_en = 1; id_wr_no = 20;
      @(negedge clk);
      checks++; if ({stall, flush} !== 2'b01) begin errors++; $display("FAIL br_mc got %b exp 01", {stall, flush}); end
      step(); idle(); id_valid = 1; id_r1_used = 1; id_r1no = 20;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_mc_not_issued got %b exp 0", stall); end
      step(); idle(); branch_taken = 1; ex_memread = 1; ex_wr_no = 3; id_r2_used = 1; id_r2no = 3;
      @(negedge clk);
      checks++; if ({stall, flush} !== 2'b11) begin errors++; $display("FAIL br_with_hazard got %b exp 11", {stall, flush}); end
   endtask

   initial begin
      rst = 1;
      idle();
      repeat (2) @(posedge clk);
      test_reset();
      test_forwarding();
      test_x0();
      test_load_use();
      test_mc();
      test_irq_drain();
      test_rst_drain();
      test_branch();
      step(); idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
